// File: rtl/drum_mul_if.sv
// drum_mul_if: request/response bus between four requesters and drum_mul_scheduler
interface drum_mul_if;
  logic [3:0] req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0] req_ready;
  logic resp_valid;
  logic resp_ready;
  logic [1:0] resp_id;
  logic [31:0] resp_r;
  logic [1:0] inflight;
  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input req_ready, resp_valid, resp_id, resp_r, inflight
  );
  modport slave (
    input req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_r, inflight
  );
endinterface

// File: rtl/drum_mul_scheduler.sv
// drum_mul_scheduler: round-robin share of one two-stage DRUM5 16x16 approximate multiplier
module drum_mul_scheduler (
  input logic clk,
  input logic rst,
  drum_mul_if.slave bus
);
  // returns {shift[3:0], mm[4:0]}; mm keeps the leading one, three bits below it and a forced 1
  function automatic logic [8:0] drum(input logic [15:0] x);
    logic [3:0] k;
    logic [3:0] sh;
    logic [15:0] t;
    k = '0;
    for (int i = 0; i < 16; i++) if (x[i]) k = 4'(i);
    sh = k > 4'd4 ? k - 4'd4 : 4'd0;
    t = x >> sh;
    return {sh, k > 4'd4 ? {t[4:1], 1'b1} : t[4:0]};
  endfunction
  logic [1:0] last;
  logic [1:0] gnt;
  logic found;
  logic stall;
  logic acc;
  logic [8:0] da;
  logic [8:0] db;
  logic s1_v;
  logic s2_v;
  logic [4:0] s1_ma;
  logic [4:0] s1_mb;
  logic [4:0] s1_sh;
  logic [1:0] s1_id;
  logic [9:0] prod;
  logic [1:0] r_id;
  logic [31:0] r_val;
  always_comb begin
    found = 1'b0;
    gnt = '0;
    for (int j = 1; j <= 4; j++)
      if (!found && bus.req_valid[2'(last + 2'(j))]) begin
        found = 1'b1;
        gnt = 2'(last + 2'(j));
      end
  end
  assign stall = s2_v && !bus.resp_ready;
  assign acc = found && !stall && !rst;
  assign bus.req_ready = acc ? 4'b1 << gnt : 4'b0;
  assign da = drum(bus.req_a[16*gnt +: 16]);
  assign db = drum(bus.req_b[16*gnt +: 16]);
  assign prod = {5'b0, s1_ma} * {5'b0, s1_mb};
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      r_id <= '0;
      r_val <= '0;
      last <= 2'd3;
    end else if (!stall) begin
      s1_v <= acc;
      s2_v <= s1_v;
      if (acc) begin
        last <= gnt;
        s1_ma <= da[4:0];
        s1_mb <= db[4:0];
        s1_sh <= {1'b0, da[8:5]} + {1'b0, db[8:5]};
        s1_id <= gnt;
      end
      if (s1_v) begin
        r_id <= s1_id;
        r_val <= {22'b0, prod} << s1_sh;
      end
    end
  end
  assign bus.resp_valid = s2_v;
  assign bus.resp_id = r_id;
  assign bus.resp_r = r_val;
  assign bus.inflight = {1'b0, s1_v} + {1'b0, s2_v};
endmodule

// File: tb/tb_drum_mul_scheduler.sv
// tb_drum_mul_scheduler: directed vectors, queue scoreboard, separate response monitor
module tb_drum_mul_scheduler;
  logic clk = 1'b0;
  logic rst;
  drum_mul_if bus();
  drum_mul_scheduler dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [15:0] va [10] = '{16'd20, 16'd1000, 16'd65535, 16'd0, 16'd7, 16'd31, 16'd32, 16'd100, 16'd255, 16'd4096};
  logic [15:0] vb [10] = '{16'd30, 16'd3, 16'd65535, 16'd1234, 16'd9, 16'd31, 16'd5, 16'd100, 16'd2, 16'd4096};
  logic [31:0] vr [10] = '{32'd600, 32'd2976, 32'd4030726144, 32'd0, 32'd63, 32'd961, 32'd170, 32'd10000, 32'd496, 32'd18939904};
  int pend [4][$];
  logic [33:0] sb [$];
  int checks = 0;
  int errors = 0;
  logic [1:0] m_last = 2'd3;
  logic m_s1v = 1'b0;
  logic m_s2v = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 4; i++) begin
        bus.req_valid[i] = pend[i].size() > 0;
        bus.req_a[16*i +: 16] = pend[i].size() > 0 ? va[pend[i][0]] : 16'h0;
        bus.req_b[16*i +: 16] = pend[i].size() > 0 ? vb[pend[i][0]] : 16'h0;
      end
    end
  end
  always @(negedge clk) begin
    logic [3:0] exp_rdy;
    logic [1:0] gi;
    logic fnd;
    logic stl;
    stl = m_s2v && !bus.resp_ready;
    fnd = 1'b0;
    gi = '0;
    for (int j = 1; j <= 4; j++) begin
      int c;
      c = (int'(m_last) + j) % 4;
      if (!fnd && bus.req_valid[c]) begin
        fnd = 1'b1;
        gi = 2'(c);
      end
    end
    exp_rdy = (fnd && !stl && !rst) ? 4'b1 << gi : 4'b0;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("resp_valid", 32'(bus.resp_valid), 32'(m_s2v));
    chk("inflight", 32'(bus.inflight), 32'(m_s1v) + 32'(m_s2v));
    if (rst) begin
      m_s1v = 1'b0;
      m_s2v = 1'b0;
      m_last = 2'd3;
      sb.delete();
    end else if (!stl) begin
      m_s2v = m_s1v;
      m_s1v = fnd;
      if (fnd) begin
        sb.push_back({gi, vr[pend[gi][0]]});
        void'(pend[gi].pop_front());
        m_last = gi;
      end
    end
  end
  always @(negedge clk) begin
    if (!rst && bus.resp_valid === 1'b1 && bus.resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got id %0d r %0d expected none", bus.resp_id, bus.resp_r);
      end else begin
        logic [33:0] e;
        e = sb.pop_front();
        chk("resp_id", 32'(bus.resp_id), 32'(e[33:32]));
        chk("resp_r", bus.resp_r, e[31:0]);
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_idle();
    int t;
    t = 0;
    while ((pend[0].size() + pend[1].size() + pend[2].size() + pend[3].size() + sb.size()) != 0 || m_s1v || m_s2v) begin
      cyc(1);
      t++;
      if (t > 200) begin
        checks++;
        errors++;
        $display("FAIL timeout: got busy expected idle");
        return;
      end
    end
  endtask
  initial begin
    logic [31:0] held;
    rst = 1'b1;
    bus.resp_ready = 1'b1;
    cyc(2);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_id", 32'(bus.resp_id), 0);
    chk("reset_r", bus.resp_r, 0);
    cyc(1);
    pend[0].push_back(0);
    wait_idle();
    pend[2].push_back(1);
    cyc(1);
    pend[0].push_back(2);
    pend[1].push_back(3);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      pend[i].push_back(4 + i);
      pend[i].push_back(9 - i);
    end
    wait_idle();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++) pend[i].push_back((i * 3 + k) % 10);
    cyc(1);
    bus.resp_ready = 1'b0;
    cyc(2);
    @(negedge clk);
    held = bus.resp_r;
    cyc(3);
    @(negedge clk);
    chk("bp_inflight", 32'(bus.inflight), 2);
    chk("bp_ready", 32'(bus.req_ready), 0);
    chk("bp_stable", bus.resp_r, held);
    cyc(1);
    bus.resp_ready = 1'b1;
    wait_idle();
    pend[3].push_back(4);
    wait_idle();
    pend[1].push_back(5);
    pend[3].push_back(6);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      pend[i].push_back(7);
      pend[i].push_back(i);
    end
    bus.resp_ready = 1'b0;
    cyc(3);
    @(negedge clk);
    chk("pre_rst_inflight", 32'(bus.inflight), 2);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(bus.resp_valid), 0);
    chk("post_rst_inflight", 32'(bus.inflight), 0);
    cyc(1);
    bus.resp_ready = 1'b1;
    wait_idle();
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
